// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Opcode constants, sequencer mode/step encoding, instruction classes
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [4:0] c_OP_LD   = 5'd0;
  localparam logic [4:0] c_OP_LDI  = 5'd1;
  localparam logic [4:0] c_OP_ST   = 5'd2;
  localparam logic [4:0] c_OP_ADD  = 5'd3;
  localparam logic [4:0] c_OP_SUB  = 5'd4;
  localparam logic [4:0] c_OP_AND  = 5'd5;
  localparam logic [4:0] c_OP_OR   = 5'd6;
  localparam logic [4:0] c_OP_ROR  = 5'd7;
  localparam logic [4:0] c_OP_ROL  = 5'd8;
  localparam logic [4:0] c_OP_SHR  = 5'd9;
  localparam logic [4:0] c_OP_SHL  = 5'd10;
  localparam logic [4:0] c_OP_ADDI = 5'd11;
  localparam logic [4:0] c_OP_ANDI = 5'd12;
  localparam logic [4:0] c_OP_ORI  = 5'd13;
  localparam logic [4:0] c_OP_MUL  = 5'd14;
  localparam logic [4:0] c_OP_DIV  = 5'd15;
  localparam logic [4:0] c_OP_NEG  = 5'd16;
  localparam logic [4:0] c_OP_NOT  = 5'd17;
  localparam logic [4:0] c_OP_BR   = 5'd18;
  localparam logic [4:0] c_OP_JR   = 5'd19;
  localparam logic [4:0] c_OP_IN   = 5'd20;
  localparam logic [4:0] c_OP_OUT  = 5'd21;
  localparam logic [4:0] c_OP_MFHI = 5'd22;
  localparam logic [4:0] c_OP_MFLO = 5'd23;
  localparam logic [4:0] c_OP_NOP  = 5'd24;
  localparam logic [4:0] c_OP_HALT = 5'd25;

  // State = mode plus a 3-bit step; step is meaningful only in MODE_RUN (T0..T7).
  typedef enum logic [1:0] {
    MODE_RESET = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_HALT  = 2'd2
  } mode_e;

  localparam logic [2:0] c_T0 = 3'd0;
  localparam logic [2:0] c_T1 = 3'd1;
  localparam logic [2:0] c_T2 = 3'd2;
  localparam logic [2:0] c_T3 = 3'd3;
  localparam logic [2:0] c_T4 = 3'd4;
  localparam logic [2:0] c_T5 = 3'd5;
  localparam logic [2:0] c_T6 = 3'd6;
  localparam logic [2:0] c_T7 = 3'd7;

  typedef enum logic [3:0] {
    CLS_NOP    = 4'd0,
    CLS_ALU_R  = 4'd1,
    CLS_ALU_I  = 4'd2,
    CLS_LDI    = 4'd3,
    CLS_MULDIV = 4'd4,
    CLS_NEGNOT = 4'd5,
    CLS_LD     = 4'd6,
    CLS_ST     = 4'd7,
    CLS_BR     = 4'd8,
    CLS_JR     = 4'd9,
    CLS_IN     = 4'd10,
    CLS_OUT    = 4'd11,
    CLS_MFHI   = 4'd12,
    CLS_MFLO   = 4'd13,
    CLS_HALT   = 4'd14
  } op_class_e;

  typedef struct packed {
    logic pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, inport_out, c_out, ba_out;
    logic pc_en, ir_en, mar_en, mdr_en, y_en, z_en, hi_en, lo_en, outport_en;
    logic read, write, inc_pc, con_in, gra, grb, grc, rin, rout;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/op_class_decode.sv
// ============================================================================
// Module   : op_class_decode
// Purpose  : Maps a 5-bit opcode to the instruction class driving the sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

module op_class_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode_i,
  output op_class_e  class_o
);

  // Unlisted opcodes decode as nop so they retire after fetch.
  always_comb begin
    class_o = CLS_NOP;
    case (opcode_i)
      c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
      c_OP_SHL, c_OP_SHR, c_OP_ROR, c_OP_ROL:  class_o = CLS_ALU_R;
      c_OP_ADDI, c_OP_ANDI, c_OP_ORI:          class_o = CLS_ALU_I;
      c_OP_LDI:                                class_o = CLS_LDI;
      c_OP_MUL, c_OP_DIV:                      class_o = CLS_MULDIV;
      c_OP_NEG, c_OP_NOT:                      class_o = CLS_NEGNOT;
      c_OP_LD:                                 class_o = CLS_LD;
      c_OP_ST:                                 class_o = CLS_ST;
      c_OP_BR:                                 class_o = CLS_BR;
      c_OP_JR:                                 class_o = CLS_JR;
      c_OP_IN:                                 class_o = CLS_IN;
      c_OP_OUT:                                class_o = CLS_OUT;
      c_OP_MFHI:                               class_o = CLS_MFHI;
      c_OP_MFLO:                               class_o = CLS_MFLO;
      c_OP_HALT:                               class_o = CLS_HALT;
      default:                                 class_o = CLS_NOP;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module   : control_unit
// Purpose  : Multi-cycle CPU sequencer (RESET, T0..T7, HALT) with decoded controls
// Revision : 1.0
// ============================================================================
`default_nettype none

module control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        stop,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        run,
  output logic        PCout, ZHighout, ZLowout, HIout, LOout, MDRout, InPortout, Cout, BAout,
  output logic        PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable, Z_enable,
  output logic        HI_enable, LO_enable, OutPort_enable,
  output logic        Read, Write, IncPC, CONin, Gra, Grb, Grc, Rin, Rout
);

  mode_e     mode_q, mode_d;
  logic [2:0] step_q, step_d;
  op_class_e w_cls;
  ctrl_t     w_ctrl;
  logic      w_last;
  logic      w_unused_ir;

  assign w_unused_ir = ^IR[26:0];

  op_class_decode u_decode (
    .opcode_i (IR[31:27]),
    .class_o  (w_cls)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      mode_q <= MODE_RESET;
      step_q <= c_T0;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    w_ctrl = '0;
    w_last = 1'b0;
    case (mode_q)
      MODE_RESET: begin
        mode_d = MODE_RUN;
        step_d = c_T0;
      end
      MODE_RUN: begin
        case (step_q)
          c_T0: begin
            w_ctrl.pc_out = 1'b1; w_ctrl.mar_en = 1'b1; w_ctrl.inc_pc = 1'b1; w_ctrl.z_en = 1'b1;
          end
          c_T1: begin
            w_ctrl.zlow_out = 1'b1; w_ctrl.pc_en = 1'b1; w_ctrl.read = 1'b1; w_ctrl.mdr_en = 1'b1;
          end
          c_T2: begin
            w_ctrl.mdr_out = 1'b1; w_ctrl.ir_en = 1'b1;
            w_last = (w_cls == CLS_NOP);
          end
          c_T3: begin
            case (w_cls)
              CLS_ALU_R, CLS_ALU_I: begin w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.y_en = 1'b1; end
              CLS_LDI, CLS_LD, CLS_ST: begin w_ctrl.grb = 1'b1; w_ctrl.ba_out = 1'b1; w_ctrl.y_en = 1'b1; end
              CLS_MULDIV: begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.y_en = 1'b1; end
              CLS_NEGNOT: begin w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.z_en = 1'b1; end
              CLS_BR:     begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.con_in = 1'b1; end
              CLS_JR:   begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.pc_en = 1'b1; w_last = 1'b1; end
              CLS_IN:   begin w_ctrl.inport_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; w_last = 1'b1; end
              CLS_OUT:  begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.outport_en = 1'b1; w_last = 1'b1; end
              CLS_MFHI: begin w_ctrl.hi_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; w_last = 1'b1; end
              CLS_MFLO: begin w_ctrl.lo_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; w_last = 1'b1; end
              default:  w_last = 1'b1;
            endcase
          end
          c_T4: begin
            case (w_cls)
              CLS_ALU_R: begin w_ctrl.grc = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.z_en = 1'b1; end
              CLS_ALU_I, CLS_LDI, CLS_LD, CLS_ST: begin w_ctrl.c_out = 1'b1; w_ctrl.z_en = 1'b1; end
              CLS_MULDIV: begin w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.z_en = 1'b1; end
              CLS_NEGNOT: begin w_ctrl.zlow_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; w_last = 1'b1; end
              CLS_BR:     begin w_ctrl.pc_out = 1'b1; w_ctrl.y_en = 1'b1; end
              default:    w_last = 1'b1;
            endcase
          end
          c_T5: begin
            case (w_cls)
              CLS_ALU_R, CLS_ALU_I, CLS_LDI: begin
                w_ctrl.zlow_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; w_last = 1'b1;
              end
              CLS_MULDIV:    begin w_ctrl.zlow_out = 1'b1; w_ctrl.lo_en = 1'b1; end
              CLS_LD, CLS_ST: begin w_ctrl.zlow_out = 1'b1; w_ctrl.mar_en = 1'b1; end
              CLS_BR:        begin w_ctrl.c_out = 1'b1; w_ctrl.z_en = 1'b1; end
              default:       w_last = 1'b1;
            endcase
          end
          c_T6: begin
            case (w_cls)
              CLS_MULDIV: begin w_ctrl.zhigh_out = 1'b1; w_ctrl.hi_en = 1'b1; w_last = 1'b1; end
              CLS_LD:     begin w_ctrl.read = 1'b1; w_ctrl.mdr_en = 1'b1; end
              CLS_ST:     begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.mdr_en = 1'b1; end
              // Branch not taken: the step still elapses, with every control low.
              CLS_BR: begin
                w_ctrl.zlow_out = CON; w_ctrl.pc_en = CON; w_last = 1'b1;
              end
              default: w_last = 1'b1;
            endcase
          end
          default: begin
            case (w_cls)
              CLS_LD:  begin w_ctrl.mdr_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; end
              CLS_ST:  w_ctrl.write = 1'b1;
              default: ;
            endcase
            w_last = 1'b1;
          end
        endcase

        if (step_q == c_T2 && w_cls == CLS_HALT) begin
          mode_d = MODE_HALT;
          step_d = c_T0;
        end else if (w_last) begin
          step_d = c_T0;
          if (stop) mode_d = MODE_HALT;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      MODE_HALT: ;
      default: begin
        mode_d = MODE_RESET;
        step_d = c_T0;
      end
    endcase
  end

  assign run            = (mode_q == MODE_RUN);
  assign PCout          = w_ctrl.pc_out;
  assign ZHighout       = w_ctrl.zhigh_out;
  assign ZLowout        = w_ctrl.zlow_out;
  assign HIout          = w_ctrl.hi_out;
  assign LOout          = w_ctrl.lo_out;
  assign MDRout         = w_ctrl.mdr_out;
  assign InPortout      = w_ctrl.inport_out;
  assign Cout           = w_ctrl.c_out;
  assign BAout          = w_ctrl.ba_out;
  assign PC_enable      = w_ctrl.pc_en;
  assign IR_enable      = w_ctrl.ir_en;
  assign MAR_enable     = w_ctrl.mar_en;
  assign MDR_enable     = w_ctrl.mdr_en;
  assign Y_enable       = w_ctrl.y_en;
  assign Z_enable       = w_ctrl.z_en;
  assign HI_enable      = w_ctrl.hi_en;
  assign LO_enable      = w_ctrl.lo_en;
  assign OutPort_enable = w_ctrl.outport_en;
  assign Read           = w_ctrl.read;
  assign Write          = w_ctrl.write;
  assign IncPC          = w_ctrl.inc_pc;
  assign CONin          = w_ctrl.con_in;
  assign Gra            = w_ctrl.gra;
  assign Grb            = w_ctrl.grb;
  assign Grc            = w_ctrl.grc;
  assign Rin            = w_ctrl.rin;
  assign Rout           = w_ctrl.rout;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Directed self-checking bench for control_unit
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_control_unit;

  logic        clk, clr, stop, CON;
  logic [31:0] IR;
  logic run, PCout, ZHighout, ZLowout, HIout, LOout, MDRout, InPortout, Cout, BAout;
  logic PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable, Z_enable, HI_enable, LO_enable, OutPort_enable;
  logic Read, Write, IncPC, CONin, Gra, Grb, Grc, Rin, Rout;

  int n_vec  = 0;
  int n_miss = 0;

  control_unit dut (
    .clk(clk), .clr(clr), .stop(stop), .IR(IR), .CON(CON), .run(run),
    .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
    .PC_enable(PC_enable), .IR_enable(IR_enable), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
    .Y_enable(Y_enable), .Z_enable(Z_enable), .HI_enable(HI_enable), .LO_enable(LO_enable),
    .OutPort_enable(OutPort_enable), .Read(Read), .Write(Write), .IncPC(IncPC), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [27:0] obs;
  assign obs = {run, PCout, ZHighout, ZLowout, HIout, LOout, MDRout, InPortout, Cout, BAout,
                PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable, Z_enable, HI_enable,
                LO_enable, OutPort_enable, Read, Write, IncPC, CONin, Gra, Grb, Grc, Rin, Rout};

  localparam logic [27:0] M_RUN  = 28'd1 << 27, M_PCO  = 28'd1 << 26, M_ZHI  = 28'd1 << 25;
  localparam logic [27:0] M_ZLO  = 28'd1 << 24, M_HIO  = 28'd1 << 23, M_LOO  = 28'd1 << 22;
  localparam logic [27:0] M_MDRO = 28'd1 << 21, M_INO  = 28'd1 << 20, M_CO   = 28'd1 << 19;
  localparam logic [27:0] M_BAO  = 28'd1 << 18, M_PCE  = 28'd1 << 17, M_IRE  = 28'd1 << 16;
  localparam logic [27:0] M_MARE = 28'd1 << 15, M_MDRE = 28'd1 << 14, M_YE   = 28'd1 << 13;
  localparam logic [27:0] M_ZE   = 28'd1 << 12, M_HIE  = 28'd1 << 11, M_LOE  = 28'd1 << 10;
  localparam logic [27:0] M_OUTE = 28'd1 << 9,  M_RD   = 28'd1 << 8,  M_WR   = 28'd1 << 7;
  localparam logic [27:0] M_INC  = 28'd1 << 6,  M_CONI = 28'd1 << 5,  M_GRA  = 28'd1 << 4;
  localparam logic [27:0] M_GRB  = 28'd1 << 3,  M_GRC  = 28'd1 << 2,  M_RIN  = 28'd1 << 1;
  localparam logic [27:0] M_ROUT = 28'd1;
  localparam logic [27:0] M_BUS  = M_PCO | M_ZHI | M_ZLO | M_HIO | M_LOO | M_MDRO | M_INO | M_CO | M_BAO | M_ROUT;

  localparam logic [27:0] E_OFF = 28'd0;
  localparam logic [27:0] E_T0  = M_RUN | M_PCO | M_MARE | M_INC | M_ZE;
  localparam logic [27:0] E_T1  = M_RUN | M_ZLO | M_PCE | M_RD | M_MDRE;
  localparam logic [27:0] E_T2  = M_RUN | M_MDRO | M_IRE;

  function automatic logic [31:0] ir_of(input logic [4:0] op);
    return {op, 27'h123_4567};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [27:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag);
    cyc(); check({tag, "_T1"}, E_T1);
    cyc(); check({tag, "_T2"}, E_T2);
  endtask

  initial begin
    clr = 1'b1; stop = 1'b0; CON = 1'b0; IR = 32'h0;
    cyc(); check("reset", E_OFF);

    // add r1,r2,r3: T0..T5 then back to T0
    clr = 1'b0; IR = ir_of(5'd3);
    cyc(); check("add_T0", E_T0);
    fetch("add");
    cyc(); check("add_T3", M_RUN | M_GRB | M_ROUT | M_YE);
    cyc(); check("add_T4", M_RUN | M_GRC | M_ROUT | M_ZE);
    cyc(); check("add_T5", M_RUN | M_ZLO | M_GRA | M_RIN);
    cyc(); check("add_ret", E_T0);

    IR = ir_of(5'd0);
    fetch("ld");
    cyc(); check("ld_T3", M_RUN | M_GRB | M_BAO | M_YE);
    cyc(); check("ld_T4", M_RUN | M_CO | M_ZE);
    cyc(); check("ld_T5", M_RUN | M_ZLO | M_MARE);
    cyc(); check("ld_T6", M_RUN | M_RD | M_MDRE);
    cyc(); check("ld_T7", M_RUN | M_MDRO | M_GRA | M_RIN);
    cyc(); check("ld_ret", E_T0);

    IR = ir_of(5'd18); CON = 1'b0;
    fetch("br0");
    cyc(); check("br0_T3", M_RUN | M_GRA | M_ROUT | M_CONI);
    cyc(); check("br0_T4", M_RUN | M_PCO | M_YE);
    cyc(); check("br0_T5", M_RUN | M_CO | M_ZE);
    cyc(); check("br0_T6", M_RUN);
    cyc(); check("br0_ret", E_T0);
    CON = 1'b1;
    fetch("br1");
    cyc(); cyc(); cyc();
    check("br1_T5", M_RUN | M_CO | M_ZE);
    cyc(); check("br1_T6", M_RUN | M_ZLO | M_PCE);
    cyc(); check("br1_ret", E_T0);
    CON = 1'b0;

    IR = ir_of(5'd1);
    fetch("ldi");
    cyc(); check("ldi_T3", M_RUN | M_GRB | M_BAO | M_YE);
    cyc(); check("ldi_T4", M_RUN | M_CO | M_ZE);
    cyc(); check("ldi_T5", M_RUN | M_ZLO | M_GRA | M_RIN);
    cyc(); check("ldi_ret", E_T0);

    IR = ir_of(5'd17);
    fetch("not");
    cyc(); check("not_T3", M_RUN | M_GRB | M_ROUT | M_ZE);
    cyc(); check("not_T4", M_RUN | M_ZLO | M_GRA | M_RIN);
    cyc(); check("not_ret", E_T0);

    IR = ir_of(5'd20);
    fetch("in");
    cyc(); check("in_T3", M_RUN | M_INO | M_GRA | M_RIN);
    cyc(); check("in_ret", E_T0);
    IR = ir_of(5'd21);
    fetch("out");
    cyc(); check("out_T3", M_RUN | M_GRA | M_ROUT | M_OUTE);
    cyc(); check("out_ret", E_T0);
    IR = ir_of(5'd19);
    fetch("jr");
    cyc(); check("jr_T3", M_RUN | M_GRA | M_ROUT | M_PCE);
    cyc(); check("jr_ret", E_T0);
    IR = ir_of(5'd22);
    fetch("mfhi");
    cyc(); check("mfhi_T3", M_RUN | M_HIO | M_GRA | M_RIN);
    cyc(); check("mfhi_ret", E_T0);
    IR = ir_of(5'd23);
    fetch("mflo");
    cyc(); check("mflo_T3", M_RUN | M_LOO | M_GRA | M_RIN);
    cyc(); check("mflo_ret", E_T0);

    // nop and an unlisted opcode both retire at T2
    IR = ir_of(5'd24);
    fetch("nop");
    cyc(); check("nop_ret", E_T0);
    IR = ir_of(5'd30);
    fetch("op30");
    cyc(); check("op30_ret", E_T0);

    // stop raised at T3 of mul: instruction completes, then HALT
    IR = ir_of(5'd14);
    fetch("mul");
    cyc(); check("mul_T3", M_RUN | M_GRA | M_ROUT | M_YE);
    stop = 1'b1;
    cyc(); check("mul_T4", M_RUN | M_GRB | M_ROUT | M_ZE);
    cyc(); check("mul_T5", M_RUN | M_ZLO | M_LOE);
    cyc(); check("mul_T6", M_RUN | M_ZHI | M_HIE);
    cyc(); check("mul_halt", E_OFF);
    stop = 1'b0;
    cyc(); check("halt_hold1", E_OFF);
    cyc(); check("halt_hold2", E_OFF);

    // clr has priority over stop
    clr = 1'b1; stop = 1'b1;
    cyc(); check("clr_over_stop", E_OFF);
    clr = 1'b0; stop = 1'b0;
    cyc(); check("st_T0", E_T0);

    // clr at T4 of st: RESET next edge, Write never seen
    IR = ir_of(5'd2);
    fetch("st");
    cyc(); check("st_T3", M_RUN | M_GRB | M_BAO | M_YE);
    cyc(); check("st_T4", M_RUN | M_CO | M_ZE);
    clr = 1'b1;
    cyc(); check("st_clr", E_OFF);
    clr = 1'b0;
    cyc(); check("st2_T0", E_T0);
    fetch("st2");
    cyc(); cyc(); cyc();
    check("st2_T5", M_RUN | M_ZLO | M_MARE);
    cyc(); check("st2_T6", M_RUN | M_GRA | M_ROUT | M_MDRE);
    cyc(); check("st2_T7", M_RUN | M_WR);
    cyc(); check("st2_ret", E_T0);

    // halt opcode parks after T2
    IR = ir_of(5'd25);
    fetch("hlt");
    cyc(); check("hlt_park", E_OFF);
    cyc(); check("hlt_hold", E_OFF);

    // stop at the last step of an ALU op (not at fetch) halts after it
    clr = 1'b1;
    cyc(); clr = 1'b0;
    cyc(); IR = ir_of(5'd4);
    fetch("sub");
    cyc(); cyc(); stop = 1'b1;
    cyc(); check("sub_T5", M_RUN | M_ZLO | M_GRA | M_RIN);
    cyc(); check("sub_halt", E_OFF);
    stop = 1'b0;

    // random-opcode run: at most one bus source per cycle
    clr = 1'b1;
    cyc(); clr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (obs == E_T0 || obs == E_OFF) begin
        logic [4:0] op;
        op = 5'($urandom_range(0, 31));
        if (op == 5'd25) op = 5'd24;
        IR = {op, 27'($urandom)};
      end
      CON = 1'($urandom_range(0, 1));
      cyc();
      n_vec++;
      assert ($countones(obs & M_BUS) <= 1) else begin
        n_miss++;
        $error("FAIL bus_excl cycle=%0d observed=%h expected=at_most_one_source", i, obs & M_BUS);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
